// File: rtl/bayer_bin2x2_pkg.sv
// Shared Bayer/RGB definitions for the 2x2 binning stage: byte lanes within a
// 16-bit quad half-word, RGB24 field offsets, line RAM address width and the quad binning function.
package bayer_bin2x2_pkg;

  localparam int PX_W      = 8;
  localparam int QUAD_W    = 16;
  localparam int RGB_W     = 24;

  // Even rows carry R,G1 pairs; odd rows carry G2,B pairs (RGGB).
  localparam int R_LSB     = 0;
  localparam int G1_LSB    = 8;
  localparam int G2_LSB    = 0;
  localparam int B_LSB     = 8;

  localparam int RGB_R_LSB = 16;
  localparam int RGB_G_LSB = 8;
  localparam int RGB_B_LSB = 0;

  function automatic int bin_ram_aw(input int max_width);
    if (max_width / 4 > 1) return $clog2(max_width / 4);
    else return 1;
  endfunction

  // Averages the two greens with a 9-bit sum, truncating; R and B pass through.
  function automatic logic [RGB_W-1:0] bin_quad(input logic [QUAD_W-1:0] even_q,
                                               input logic [QUAD_W-1:0] odd_q);
    logic [PX_W-1:0] r, g1, g2, b;
    logic [PX_W:0]   g_sum;
    logic [RGB_W-1:0] rgb;
    r     = even_q[R_LSB +: PX_W];
    g1    = even_q[G1_LSB +: PX_W];
    g2    = odd_q[G2_LSB +: PX_W];
    b     = odd_q[B_LSB +: PX_W];
    g_sum = {1'b0, g1} + {1'b0, g2};
    rgb   = '0;
    rgb[RGB_R_LSB +: PX_W] = r;
    rgb[RGB_G_LSB +: PX_W] = g_sum[PX_W:1];
    rgb[RGB_B_LSB +: PX_W] = b;
    return rgb;
  endfunction

endpackage

// File: rtl/bayer_bin2x2_line_ram.sv
// Simple dual-port 32-bit line buffer with registered read, shaped to map onto iCE40 EBR.
module bin_line_ram #(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bayer_bin2x2.sv
// RAW8 RGGB 2x2 binning: even rows go to a line RAM, odd rows combine with it into two RGB24 pixels per word.
// Optional per-frame green statistics are enabled with the BAYER_BIN2X2_STATS_EN macro.
module bayer_bin2x2
  import bayer_bin2x2_pkg::*;
#(
  parameter int MAX_WIDTH  = 2560,
  parameter int MAX_HEIGHT = 1920,
  parameter int X_BITS     = 10,
  parameter int Y_BITS     = 10
) (
  input  logic              video_clk,
  input  logic              reset,
  input  logic [31:0]       payload_data,
  input  logic              payload_valid,
  input  logic              in_line,
  input  logic              in_frame,
  output logic [47:0]       out_data,
  output logic              out_valid,
  output logic [X_BITS-1:0] out_x,
  output logic [Y_BITS-1:0] out_y,
  output logic              out_frame_start,
  output logic              overflow,
  output logic [31:0]       frame_g_sum,
  output logic              frame_g_sum_valid
);

  localparam int                DEPTH   = MAX_WIDTH / 4;
  localparam int                AW      = bin_ram_aw(MAX_WIDTH);
  localparam logic [X_BITS:0]   DEPTH_W = (X_BITS + 1)'(DEPTH);
  localparam logic [Y_BITS-1:0] Y_MAX   = Y_BITS'(MAX_HEIGHT / 2 - 1);

  // No back-pressure anywhere: a word is taken whenever payload_valid is high
  // inside in_line and in_frame, and out_valid is a single-cycle strobe that
  // qualifies out_data/out_x/out_y; the consumer must take it that cycle.

  logic prev_line, prev_frame;
  logic line_start, line_end, frame_start, frame_end;
  logic accept, in_range;
  logic [X_BITS:0] idx, eff_idx;
  logic row_odd, eff_row_odd;
  logic [Y_BITS-1:0] y, eff_y;
  logic first_pend, eff_first;
  logic ram_we, ram_re;
  logic [31:0] ram_rdata;

  logic              s1_valid, s1_first;
  logic [31:0]       s1_odd;
  logic [X_BITS-1:0] s1_x;
  logic [Y_BITS-1:0] s1_y;

  always_comb begin
    line_start  = in_line & ~prev_line;
    line_end    = ~in_line & prev_line;
    frame_start = in_frame & ~prev_frame;
    frame_end   = ~in_frame & prev_frame;
    accept      = payload_valid & in_line & in_frame;
    eff_idx     = line_start ? '0 : idx;
    in_range    = eff_idx < DEPTH_W;
    eff_row_odd = frame_start ? 1'b0 : row_odd;
    eff_y       = frame_start ? '0 : y;
    eff_first   = frame_start | first_pend;
    ram_we      = accept & in_range & ~eff_row_odd;
    ram_re      = accept & in_range & eff_row_odd;
  end

  bin_line_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_line_ram (
    .clk   (video_clk),
    .we    (ram_we),
    .waddr (eff_idx[AW-1:0]),
    .wdata (payload_data),
    .re    (ram_re),
    .raddr (eff_idx[AW-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge video_clk) begin
    if (reset) begin
      prev_line       <= 1'b0;
      prev_frame      <= 1'b0;
      idx             <= '0;
      row_odd         <= 1'b0;
      y               <= '0;
      first_pend      <= 1'b0;
      overflow        <= 1'b0;
      s1_valid        <= 1'b0;
      s1_first        <= 1'b0;
      s1_odd          <= '0;
      s1_x            <= '0;
      s1_y            <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_x           <= '0;
      out_y           <= '0;
      out_frame_start <= 1'b0;
    end else begin
      prev_line  <= in_line;
      prev_frame <= in_frame;

      if (frame_start) begin
        row_odd    <= 1'b0;
        y          <= '0;
        overflow   <= 1'b0;
        first_pend <= 1'b1;
      end else if (line_end) begin
        row_odd <= ~row_odd;
        if (row_odd && (y != Y_MAX)) y <= y + 1'b1;
      end

      if (accept) begin
        idx <= in_range ? eff_idx + 1'b1 : DEPTH_W;
        if (!in_range) overflow <= 1'b1;
      end

      if (ram_re) first_pend <= 1'b0;

      // Stage 1: odd word and coordinates wait alongside the RAM read.
      s1_valid <= ram_re;
      if (ram_re) begin
        s1_odd   <= payload_data;
        s1_x     <= eff_idx[X_BITS-1:0];
        s1_y     <= eff_y;
        s1_first <= eff_first;
      end

      out_valid       <= s1_valid;
      out_frame_start <= s1_valid & s1_first;
      if (s1_valid) begin
        out_data <= {bin_quad(ram_rdata[31:16], s1_odd[31:16]),
                     bin_quad(ram_rdata[15:0],  s1_odd[15:0])};
        out_x    <= s1_x;
        out_y    <= s1_y;
      end
    end
  end

`ifdef BAYER_BIN2X2_STATS_EN
  logic [31:0] g_acc, acc_next;
  logic [32:0] acc_sum;
  logic [8:0]  beat_g;

  always_comb begin
    beat_g   = out_valid ? ({1'b0, out_data[39:32]} + {1'b0, out_data[15:8]}) : '0;
    acc_sum  = {1'b0, g_acc} + 33'(beat_g);
    acc_next = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
  end

  // A beat landing in the frame_end cycle is still counted in the latched sum.
  always_ff @(posedge video_clk) begin
    if (reset) begin
      g_acc             <= '0;
      frame_g_sum       <= '0;
      frame_g_sum_valid <= 1'b0;
    end else if (frame_end) begin
      frame_g_sum       <= acc_next;
      frame_g_sum_valid <= 1'b1;
      g_acc             <= '0;
    end else begin
      frame_g_sum_valid <= 1'b0;
      g_acc             <= frame_start ? '0 : acc_next;
    end
  end
`else
  assign frame_g_sum       = '0;
  assign frame_g_sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_bayer_bin2x2.sv
// Directed bench for bayer_bin2x2 (MAX_WIDTH=16, MAX_HEIGHT=8); output beats are captured into queues
// at the falling edge and each scenario task checks them against hand-derived values.
module tb_bayer_bin2x2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] payload_data = '0;
  logic        payload_valid = 1'b0;
  logic        in_line = 1'b0;
  logic        in_frame = 1'b0;
  logic [47:0] out_data;
  logic        out_valid;
  logic [9:0]  out_x;
  logic [9:0]  out_y;
  logic        out_frame_start;
  logic        overflow;
  logic [31:0] frame_g_sum;
  logic        frame_g_sum_valid;

  bayer_bin2x2 #(
    .MAX_WIDTH (16),
    .MAX_HEIGHT(8),
    .X_BITS    (10),
    .Y_BITS    (10)
  ) dut (
    .video_clk        (clk),
    .reset            (reset),
    .payload_data     (payload_data),
    .payload_valid    (payload_valid),
    .in_line          (in_line),
    .in_frame         (in_frame),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_x            (out_x),
    .out_y            (out_y),
    .out_frame_start  (out_frame_start),
    .overflow         (overflow),
    .frame_g_sum      (frame_g_sum),
    .frame_g_sum_valid(frame_g_sum_valid)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // capture of output beats
  logic [47:0] cap_data[$];
  logic [9:0]  cap_x[$];
  logic [9:0]  cap_y[$];
  logic        cap_fs[$];
  int          cap_cyc[$];

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      cap_data.push_back(out_data);
      cap_x.push_back(out_x);
      cap_y.push_back(out_y);
      cap_fs.push_back(out_frame_start);
      cap_cyc.push_back(cyc);
    end
  end

  logic [31:0] line_buf[8];
  int          last_drive_cyc;

  function automatic logic [47:0] exp_bin(input logic [31:0] e, input logic [31:0] o);
    logic [47:0] r;
    logic [8:0]  s;
    r = '0;
    for (int k = 0; k < 2; k++) begin
      s = {1'b0, e[16*k+8 +: 8]} + {1'b0, o[16*k +: 8]};
      r[24*k +: 24] = {e[16*k +: 8], s[8:1], o[16*k+8 +: 8]};
    end
    return r;
  endfunction

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap;
    cap_data.delete(); cap_x.delete(); cap_y.delete(); cap_fs.delete(); cap_cyc.delete();
  endtask

  task automatic drive_line(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        repeat (int'($urandom_range(0, 2))) begin
          payload_valid = 1'b0;
          tick();
        end
      end
      in_line = 1'b1;
      payload_valid = 1'b1;
      payload_data = line_buf[i];
      last_drive_cyc = cyc;
      tick();
    end
    payload_valid = 1'b0;
    in_line = 1'b0;
    tick();
    tick();
  endtask

  task automatic frame_begin;
    in_frame = 1'b1;
    tick();
  endtask

  task automatic frame_close;
    tick();
    tick();
    in_frame = 1'b0;
    tick();
    tick();
  endtask

  // scenarios
  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 48'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (out_x !== 10'd0 || out_y !== 10'd0) begin bad++; $display("FAIL reset_xy got=%0d/%0d want=0/0", out_x, out_y); end
    total++; if (out_frame_start !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", out_frame_start, overflow); end
    total++; if (frame_g_sum !== 32'h0 || frame_g_sum_valid !== 1'b0) begin bad++; $display("FAIL reset_stats got=%h/%b want=0/0", frame_g_sum, frame_g_sum_valid); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int odd_cyc;
    clear_cap();
    frame_begin();
    line_buf[0] = 32'h4030_2010;
    drive_line(1, 1'b0);
    line_buf[0] = 32'h8070_6050;
    drive_line(1, 1'b0);
    odd_cyc = last_drive_cyc;
    frame_close();
    total++; if (cap_data.size() != 1) begin bad++; $display("FAIL basic_count got=%0d want=1", cap_data.size()); end
    if (cap_data.size() >= 1) begin
      total++; if (cap_data[0] !== 48'h305880_103860) begin bad++; $display("FAIL basic_data got=%h want=305880103860", cap_data[0]); end
      total++; if (cap_x[0] !== 10'd0 || cap_y[0] !== 10'd0) begin bad++; $display("FAIL basic_xy got=%0d/%0d want=0/0", cap_x[0], cap_y[0]); end
      total++; if (cap_fs[0] !== 1'b1) begin bad++; $display("FAIL basic_frame_start got=%b want=1", cap_fs[0]); end
      total++; if (cap_cyc[0] != odd_cyc + 2) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", cap_cyc[0], odd_cyc + 2); end
    end
  endtask

  task automatic test_overflow;
    clear_cap();
    frame_begin();
    for (int i = 0; i < 6; i++) line_buf[i] = 32'h4030_2010;
    drive_line(6, 1'b0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_even got=%b want=1", overflow); end
    for (int i = 0; i < 6; i++) line_buf[i] = 32'h8070_6050;
    drive_line(6, 1'b0);
    frame_close();
    total++; if (cap_data.size() != 4) begin bad++; $display("FAIL ovf_count got=%0d want=4", cap_data.size()); end
    for (int i = 0; i < cap_data.size(); i++) begin
      total++; if (cap_x[i] !== 10'(i)) begin bad++; $display("FAIL ovf_x%0d got=%0d want=%0d", i, cap_x[i], i); end
      total++; if (cap_data[i] !== 48'h305880_103860) begin bad++; $display("FAIL ovf_data%0d got=%h want=305880103860", i, cap_data[i]); end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    frame_begin();
    tick();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    in_frame = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_gaps;
    logic [31:0] pat[4][4];
    logic [47:0] ref_data[8];
    int n_ref;
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < 4; i++)
        pat[l][i] = 32'h0102_0304 * (l + 1) + 32'h1111_1111 * i + 32'h0F00_00A0 * l;
    for (int run = 0; run < 2; run++) begin
      clear_cap();
      frame_begin();
      for (int l = 0; l < 4; l++) begin
        for (int i = 0; i < 4; i++) line_buf[i] = pat[l][i];
        drive_line(4, run == 1);
      end
      frame_close();
      total++; if (cap_data.size() != 8) begin bad++; $display("FAIL gaps_count run%0d got=%0d want=8", run, cap_data.size()); end
      for (int b = 0; b < cap_data.size() && b < 8; b++) begin
        total++;
        if (cap_data[b] !== exp_bin(pat[2*(b/4)][b%4], pat[2*(b/4)+1][b%4])) begin
          bad++; $display("FAIL gaps_data run%0d beat%0d got=%h want=%h", run, b, cap_data[b], exp_bin(pat[2*(b/4)][b%4], pat[2*(b/4)+1][b%4]));
        end
        total++; if (cap_x[b] !== 10'(b % 4) || cap_y[b] !== 10'(b / 4)) begin bad++; $display("FAIL gaps_xy run%0d beat%0d got=%0d/%0d want=%0d/%0d", run, b, cap_x[b], cap_y[b], b % 4, b / 4); end
        total++; if (cap_fs[b] !== (b == 0)) begin bad++; $display("FAIL gaps_fs run%0d beat%0d got=%b want=%b", run, b, cap_fs[b], b == 0); end
        if (run == 0) ref_data[b] = cap_data[b];
        else begin
          total++; if (cap_data[b] !== ref_data[b]) begin bad++; $display("FAIL gaps_vs_nogap beat%0d got=%h want=%h", b, cap_data[b], ref_data[b]); end
        end
      end
      n_ref = cap_data.size();
    end
  endtask

  task automatic test_green;
    clear_cap();
    frame_begin();
    line_buf[0] = 32'hFF22_FF11;
    drive_line(1, 1'b0);
    line_buf[0] = 32'h44FF_3301;
    drive_line(1, 1'b0);
    frame_close();
    total++; if (cap_data.size() != 1) begin bad++; $display("FAIL green_count got=%0d want=1", cap_data.size()); end
    if (cap_data.size() >= 1) begin
      total++; if (cap_data[0] !== 48'h22FF44_118033) begin bad++; $display("FAIL green_data got=%h want=22ff44118033", cap_data[0]); end
      total++; if (cap_x[0] !== 10'd0) begin bad++; $display("FAIL green_x got=%0d want=0", cap_x[0]); end
    end
  endtask

  task automatic test_y_sat;
    clear_cap();
    frame_begin();
    for (int l = 0; l < 10; l++) begin
      line_buf[0] = (l % 2 == 0) ? 32'h1020_3040 : 32'h5060_7080;
      drive_line(1, 1'b0);
    end
    frame_close();
    total++; if (cap_y.size() != 5) begin bad++; $display("FAIL ysat_count got=%0d want=5", cap_y.size()); end
    for (int b = 0; b < cap_y.size() && b < 5; b++) begin
      total++; if (cap_y[b] !== 10'((b > 3) ? 3 : b)) begin bad++; $display("FAIL ysat_y%0d got=%0d want=%0d", b, cap_y[b], (b > 3) ? 3 : b); end
    end
  endtask

  task automatic test_reset_mid;
    int n_before;
    clear_cap();
    frame_begin();
    line_buf[0] = 32'h4030_2010;
    drive_line(1, 1'b0);
    line_buf[0] = 32'h8070_6050;
    drive_line(1, 1'b0);
    for (int i = 0; i < 4; i++) line_buf[i] = 32'h4030_2010;
    drive_line(4, 1'b0);
    in_line = 1'b1;
    payload_valid = 1'b1;
    payload_data = 32'h8070_6050;
    tick();
    payload_data = 32'h8070_6050;
    tick();
    reset = 1'b1;
    payload_valid = 1'b0;
    tick();
    n_before = cap_data.size();
    total++; if (n_before != 2) begin bad++; $display("FAIL rstmid_before got=%0d want=2", n_before); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
    in_line = 1'b0;
    in_frame = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    total++; if (cap_data.size() != n_before) begin bad++; $display("FAIL rstmid_flush got=%0d want=%0d", cap_data.size(), n_before); end
    clear_cap();
    frame_begin();
    line_buf[0] = 32'hFF22_FF11;
    drive_line(1, 1'b0);
    line_buf[0] = 32'h44FF_3301;
    drive_line(1, 1'b0);
    frame_close();
    total++; if (cap_data.size() != 1) begin bad++; $display("FAIL rstmid_next_count got=%0d want=1", cap_data.size()); end
    if (cap_data.size() >= 1) begin
      total++; if (cap_y[0] !== 10'd0 || cap_fs[0] !== 1'b1) begin bad++; $display("FAIL rstmid_next got y=%0d fs=%b want y=0 fs=1", cap_y[0], cap_fs[0]); end
      total++; if (cap_data[0] !== 48'h22FF44_118033) begin bad++; $display("FAIL rstmid_next_data got=%h want=22ff44118033", cap_data[0]); end
    end
  endtask

  task automatic test_stats;
    logic [31:0] exp_sum;
    logic        exp_pulse;
`ifdef BAYER_BIN2X2_STATS_EN
    exp_sum = 32'h200;
    exp_pulse = 1'b1;
`else
    exp_sum = 32'h0;
    exp_pulse = 1'b0;
`endif
    clear_cap();
    frame_begin();
    for (int l = 0; l < 4; l++) begin
      line_buf[0] = (l % 2 == 0) ? 32'h8000_8000 : 32'h0080_0080;
      drive_line(1, 1'b0);
    end
    total++; if (cap_data.size() != 2) begin bad++; $display("FAIL stats_count got=%0d want=2", cap_data.size()); end
    if (cap_data.size() >= 1) begin
      total++; if (cap_data[0] !== 48'h008000_008000) begin bad++; $display("FAIL stats_data got=%h want=008000008000", cap_data[0]); end
    end
    tick();
    tick();
    in_frame = 1'b0;
    tick();
    total++; if (frame_g_sum_valid !== exp_pulse) begin bad++; $display("FAIL stats_pulse got=%b want=%b", frame_g_sum_valid, exp_pulse); end
    total++; if (frame_g_sum !== exp_sum) begin bad++; $display("FAIL stats_sum got=%h want=%h", frame_g_sum, exp_sum); end
    tick();
    total++; if (frame_g_sum_valid !== 1'b0) begin bad++; $display("FAIL stats_pulse_end got=%b want=0", frame_g_sum_valid); end
    total++; if (frame_g_sum !== exp_sum) begin bad++; $display("FAIL stats_hold got=%h want=%h", frame_g_sum, exp_sum); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_gaps();
    test_green();
    test_y_sat();
    test_reset_mid();
    test_stats();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=done");
    $fatal(1, "timeout");
  end

endmodule
